mux_4x1_rr_arbiter: RTL and testbench
=====================================

Name: mux_4x1_rr_arbiter

Overview:
- Round-robin arbiter and select sequencer for a shared 4:1 datapath multiplexer.
- Four requesters compete for one output. The block grants one requester at a time, drives the mux select lines s1:s0, and presents the selected source on out with a valid flag.
- Grant tenure is bounded by MAX_HOLD cycles when other requesters are waiting, which guarantees fairness.

Parameters:
- DW, 1: data width of each source and of out.
- MAX_HOLD, 8: maximum consecutive grant cycles while any other request is pending. Legal range 2..255.
- CNT_W, 8: hold-counter width. Must be at least clog2(MAX_HOLD).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req  in  4  request levels; req[0]=a, req[1]=b, req[2]=c, req[3]=d
- a  in  DW  source 0
- b  in  DW  source 1
- c  in  DW  source 2
- d  in  DW  source 3
- gnt  out  4  one-hot grant, registered
- s0  out  1  mux select LSB, registered
- s1  out  1  mux select MSB, registered
- out  out  DW  selected source, combinational from registered select
- out_valid  out  1  gnt of owner AND req of owner
- busy  out  1  high in GRANT state

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: gnt=0, {s1,s0}=00, out_valid=0, busy=0, state=IDLE, hold_cnt=0, last_owner=3 (so req[0] wins first).
- Select encoding {s1,s0}: 00=a, 01=b, 10=c, 11=d. out = mux(a,b,c,d) on {s1,s0} in every cycle, including IDLE (shows a after reset).
- States: IDLE and GRANT.
- IDLE:
  - If req != 0 at edge N, then at edge N the state goes to GRANT, owner = round-robin winner, gnt is one-hot on the winner, select = winner index, hold_cnt=0.
  - Latency from req rising to gnt visible: 1 cycle.
- Round-robin winner: first asserted req scanning last_owner+1, +2, +3, +4 (mod 4). last_owner updates to the winner on every grant.
- GRANT, per edge, in priority order:
  - Owner req low:
    - If other req are pending, grant passes directly to the RR winner with no idle cycle (back-to-back).
    - If none are pending, go to IDLE with gnt=0. Select keeps its last value.
  - Owner req high, hold_cnt == MAX_HOLD-1, and any other req high: forced rotation to the RR winner; hold_cnt=0.
  - Owner req high, hold_cnt == MAX_HOLD-1, and no other req: owner keeps the grant; hold_cnt wraps to 0.
  - Otherwise: hold_cnt increments.
- Simultaneous requests: exactly one winner per the RR scan; gnt is never multi-hot.
- Reset mid-grant: gnt=0 and IDLE at the reset edge. A pending request is re-arbitrated starting from req[0].
- out_valid falls in the same cycle the owner drops req (combinational).
- Assertions: $onehot0(gnt); when gnt != 0, gnt[{s1,s0}] == 1.

Optional Feature:
- MUX_ARB_FIXED_PRIO_EN defined:
  - The RR scan is replaced by fixed priority req[0] > req[1] > req[2] > req[3].
  - Forced rotation still occurs at MAX_HOLD, but the new winner is the highest-priority other requester.
  - last_owner is unused.
- Undefined: round-robin behaviour as above.

Decomposition:
- Package mux_arb_pkg:
  - select-encoding localparams SEL_A..SEL_D
  - state enum {IDLE, GRANT}
  - function rr_pick(req, last) returning a 2-bit index
  - function onehot4(idx)
- Sub-module mux_4x1_w: width-parameterized (DW) combinational 4:1 mux driven by s0 and s1. Instantiated once for out.
- The arbiter FSM, hold counter and pointer live in the top module.

Test Plan:
- Single requester: rst for 2 cycles, then req=0001 held for 20 cycles.
  - Expect gnt=0001 one cycle later, {s1,s0}=00, out=a, out_valid=1 throughout.
  - No rotation; hold_cnt wraps at 7.
- All request from reset: req=1111 from reset release, MAX_HOLD=8.
  - Expect grant order 0,1,2,3,0, each tenure exactly 8 cycles, no gap cycles.
- Back-to-back release: owner=1 drops req while req=0101 pending.
  - Expect next edge gnt=0100, {s1,s0}=10, busy stays 1.
- Idle return: sole owner=2 drops req.
  - Expect gnt=0, busy=0, out_valid=0 next edge; {s1,s0} stays 10.
- Reset mid-grant: rst pulsed during gnt=1000 with req=1001 held.
  - Expect gnt=0 at the reset edge, then gnt=0001 one cycle after rst deasserts.
- With MUX_ARB_FIXED_PRIO_EN: req=1110.
  - Expect grant 1; after 8 cycles, 2; after 8 more, 1 again. Requester 3 is never granted while 1 and 2 remain asserted.

Source files
------------

// File: rtl/mux_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_arb_pkg
//  Description : Shared definitions for the 4:1 mux round-robin arbiter:
//                select encodings, FSM state type and the winner-selection
//                helper functions.
//  Revision    : 1.0 - initial release
// ============================================================================
package mux_arb_pkg;

    // Select encoding driven on {s1,s0}
    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Round-robin scan: first asserted request at last+1, last+2, last+3,
    // last+4 (mod 4). The previous owner is therefore considered last.
    // Callers only use the result when req is non-zero.
    function automatic logic [1:0] rr_pick(input logic [3:0] req,
                                           input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Fixed priority: req[0] > req[1] > req[2] > req[3]
    function automatic logic [1:0] fixed_pick(input logic [3:0] req);
        logic [1:0] pick;
        if (req[0])      pick = SEL_A;
        else if (req[1]) pick = SEL_B;
        else if (req[2]) pick = SEL_C;
        else             pick = SEL_D;
        return pick;
    endfunction

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage : mux_arb_pkg
`default_nettype wire

// File: rtl/mux_4x1_w.sv
`default_nettype none
// ============================================================================
//  Module      : mux_4x1_w
//  Description : Width-parameterized combinational 4:1 multiplexer.
//                {s1_i,s0_i}: 00 -> a_i, 01 -> b_i, 10 -> c_i, 11 -> d_i.
//  Ports       : a_i..d_i  [DW]  data sources
//                s0_i, s1_i      select LSB / MSB
//                y_o       [DW]  selected source
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_4x1_w
    import mux_arb_pkg::*;
#(
    parameter int DW = 1
) (
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic [DW-1:0] c_i,
    input  logic [DW-1:0] d_i,
    input  logic          s0_i,
    input  logic          s1_i,
    output logic [DW-1:0] y_o
);

    logic [1:0] w_sel;

    assign w_sel = {s1_i, s0_i};

    always_comb begin
        y_o = a_i;
        case (w_sel)
            SEL_A:   y_o = a_i;
            SEL_B:   y_o = b_i;
            SEL_C:   y_o = c_i;
            SEL_D:   y_o = d_i;
            default: y_o = a_i;
        endcase
    end

endmodule : mux_4x1_w
`default_nettype wire

// File: rtl/mux_4x1_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mux_4x1_rr_arbiter
//  Description : Round-robin arbiter and select sequencer for a shared 4:1
//                datapath mux. One requester owns the output at a time; the
//                tenure is capped at MAX_HOLD cycles while others wait.
//  Options     : define MUX_ARB_FIXED_PRIO_EN to replace the round-robin scan
//                with fixed priority req[0] > req[1] > req[2] > req[3].
//  Ports       : clk, rst         clock, synchronous active-high reset
//                req   [4]        request levels (a,b,c,d = bit 0..3)
//                a..d  [DW]       data sources
//                gnt   [4]        registered one-hot grant
//                s0, s1           registered mux select
//                out   [DW]       source selected by {s1,s0}
//                out_valid        owner granted and still requesting
//                busy             FSM in GRANT
//  Revision    : 1.0 - initial release
// ============================================================================
module mux_4x1_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DW       = 1,
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    req,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] c,
    input  logic [DW-1:0] d,
    output logic [3:0]    gnt,
    output logic          s0,
    output logic          s1,
    output logic [DW-1:0] out,
    output logic          out_valid,
    output logic          busy
);

    // ------------------------------------------------------------------
    // Parameter sanity
    // ------------------------------------------------------------------
    if (MAX_HOLD < 2 || MAX_HOLD > 255 || CNT_W < $clog2(MAX_HOLD)) begin : g_param_check
        $error("mux_4x1_rr_arbiter: illegal MAX_HOLD/CNT_W combination");
    end

    localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_e       state_q,    state_d;
    logic [3:0]       gnt_q,      gnt_d;
    logic [1:0]       sel_q,      sel_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    logic             w_owner_req;
    logic [3:0]       w_cand;
    logic [1:0]       w_win;
    logic             w_take;

    // The owner index is always the current select while in GRANT.
    assign w_owner_req = req[sel_q];

    // Candidates exclude the current owner, so a forced rotation never
    // re-picks it. In IDLE gnt_q is zero and every request is a candidate.
    assign w_cand = req & ~gnt_q;

`ifdef MUX_ARB_FIXED_PRIO_EN
    assign w_win = fixed_pick(w_cand);
`else
    logic [1:0] last_q, last_d;

    assign w_win  = rr_pick(w_cand, last_q);
    assign last_d = w_take ? w_win : last_q;

    // Reset to 3 so the first scan after reset starts at req[0].
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= SEL_D;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Next-state decision
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        hold_cnt_d = hold_cnt_q;
        w_take     = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    w_take = 1'b1;
                end
            end
            GRANT: begin
                if (!w_owner_req) begin
                    if (|w_cand) begin
                        // Hand over directly, no idle bubble.
                        w_take = 1'b1;
                    end else begin
                        // Select is left alone so out keeps showing the
                        // last owner's source.
                        state_d    = IDLE;
                        gnt_d      = 4'b0000;
                        hold_cnt_d = '0;
                    end
                end else if (hold_cnt_q == c_HOLD_LAST) begin
                    if (|w_cand) begin
                        w_take = 1'b1;
                    end else begin
                        // Nobody waiting: owner keeps the grant, new window.
                        hold_cnt_d = '0;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                gnt_d      = 4'b0000;
                hold_cnt_d = '0;
            end
        endcase

        if (w_take) begin
            state_d    = GRANT;
            gnt_d      = onehot4(w_win);
            sel_d      = w_win;
            hold_cnt_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // FSM registers (all outputs except out/out_valid come from here)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= 4'b0000;
            sel_q      <= SEL_A;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign gnt       = gnt_q;
    assign s0        = sel_q[0];
    assign s1        = sel_q[1];
    assign busy      = (state_q == GRANT);
    // Combinational on req so it drops in the same cycle the owner releases.
    assign out_valid = |(gnt_q & req);

    mux_4x1_w #(
        .DW (DW)
    ) u_mux (
        .a_i  (a),
        .b_i  (b),
        .c_i  (c),
        .d_i  (d),
        .s0_i (sel_q[0]),
        .s1_i (sel_q[1]),
        .y_o  (out)
    );

    // ------------------------------------------------------------------
    // Structural invariants
    // ------------------------------------------------------------------
`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(gnt_q));
            if (|gnt_q) begin
                assert (gnt_q[sel_q]);
            end
            assert ((state_q == GRANT) == (|gnt_q));
        end
    end
`endif

endmodule : mux_4x1_rr_arbiter
`default_nettype wire

// File: tb/tb_mux_4x1_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux_4x1_rr_arbiter
//  Description : Directed self-checking bench for mux_4x1_rr_arbiter
//                (DW=8, MAX_HOLD=8). Honours MUX_ARB_FIXED_PRIO_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_4x1_rr_arbiter;

    localparam int DW       = 8;
    localparam int MAX_HOLD = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req;
    logic [DW-1:0] a, b, c, d;
    logic [3:0]    gnt;
    logic          s0, s1;
    logic [DW-1:0] out;
    logic          out_valid;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mux_4x1_rr_arbiter #(
        .DW       (DW),
        .MAX_HOLD (MAX_HOLD),
        .CNT_W    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .gnt       (gnt),
        .s0        (s0),
        .s1        (s1),
        .out       (out),
        .out_valid (out_valid),
        .busy      (busy)
    );

    // Advance one clock and settle away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req = 4'b0000;
        do_reset(2);
        n_checks++;
        if (gnt !== 4'b0000) begin n_errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        n_checks++;
        if ({s1, s0} !== 2'b00) begin n_errors++; $display("FAIL reset_sel: got %b want 00", {s1, s0}); end
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_errors++; $display("FAIL reset_flags: got ov=%b busy=%b want 0 0", out_valid, busy);
        end
        n_checks++;
        if (out !== a) begin n_errors++; $display("FAIL reset_out: got %h want %h", out, a); end
        // Idle with no request must stay idle.
        step();
        n_checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            n_errors++; $display("FAIL idle_hold: got gnt=%b busy=%b want 0000 0", gnt, busy);
        end
    endtask

    // req=0001 for a long stretch: never rotates, hold counter wraps.
    // Then a second requester arrives mid-window and must wait for the wrap.
    task automatic test_single();
        req = 4'b0001;
        step();
        n_checks++;
        if (gnt !== 4'b0001 || {s1, s0} !== 2'b00 || out !== a || out_valid !== 1'b1 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL single_first: got gnt=%b sel=%b out=%h ov=%b busy=%b want 0001 00 %h 1 1",
                     gnt, {s1, s0}, out, out_valid, busy, a);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            n_checks++;
            if (gnt !== 4'b0001 || out !== a || out_valid !== 1'b1) begin
                n_errors++;
                $display("FAIL single_hold[%0d]: got gnt=%b out=%h ov=%b want 0001 %h 1", i, gnt, out, out_valid, a);
            end
        end
        // Counter now at 20 mod 8 = 4: three more cycles of owner 0, then rotate.
        req = 4'b0011;
        for (int i = 1; i <= 4; i++) begin
            step();
            n_checks++;
            if (gnt !== ((i < 4) ? 4'b0001 : 4'b0010)) begin
                n_errors++;
                $display("FAIL single_wrap_rot[%0d]: got %b want %b", i, gnt, (i < 4) ? 4'b0001 : 4'b0010);
            end
        end
        n_checks++;
        if ({s1, s0} !== 2'b01 || out !== b) begin
            n_errors++; $display("FAIL single_rot_sel: got sel=%b out=%h want 01 %h", {s1, s0}, out, b);
        end
        req = 4'b0000;
        step();
        n_checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            n_errors++; $display("FAIL single_idle: got gnt=%b busy=%b want 0000 0", gnt, busy);
        end
    endtask

`ifndef MUX_ARB_FIXED_PRIO_EN
    // req=1111 from reset release: 0,1,2,3,0 with 8-cycle tenures, no gaps.
    task automatic test_all_rr();
        logic [3:0] exp_gnt;
        rst = 1'b1;
        req = 4'b1111;
        step();
        rst = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            step();
            exp_gnt = 4'b0001 << (((k - 1) / MAX_HOLD) % 4);
            n_checks++;
            if (gnt !== exp_gnt || busy !== 1'b1) begin
                n_errors++;
                $display("FAIL all_rr[%0d]: got gnt=%b busy=%b want %b 1", k, gnt, busy, exp_gnt);
            end
        end
        req = 4'b0000;
        step();
    endtask
`else
    // req=1110: 1 for 8, 2 for 8, back to 1; requester 3 is starved.
    task automatic test_fixed_prio();
        logic [3:0] exp_gnt;
        do_reset(1);
        req = 4'b1110;
        for (int k = 1; k <= 24; k++) begin
            step();
            exp_gnt = (k <= 8 || k > 16) ? 4'b0010 : 4'b0100;
            n_checks++;
            if (gnt !== exp_gnt) begin
                n_errors++;
                $display("FAIL fixed_prio[%0d]: got %b want %b", k, gnt, exp_gnt);
            end
        end
        req = 4'b0000;
        step();
    endtask
`endif

    // Owner 1 drops while 0 and 2 wait: next winner is 2 with no bubble.
    task automatic test_back_to_back();
        do_reset(1);
        req = 4'b0010;
        step();
        n_checks++;
        if (gnt !== 4'b0010) begin n_errors++; $display("FAIL b2b_setup: got %b want 0010", gnt); end
        req = 4'b0101;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++; $display("FAIL b2b_ov_drop: got %b want 0", out_valid);
        end
        step();
`ifndef MUX_ARB_FIXED_PRIO_EN
        n_checks++;
        if (gnt !== 4'b0100 || {s1, s0} !== 2'b10 || busy !== 1'b1 || out !== c || out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_handover: got gnt=%b sel=%b busy=%b out=%h ov=%b want 0100 10 1 %h 1",
                     gnt, {s1, s0}, busy, out, out_valid, c);
        end
`else
        n_checks++;
        if (gnt !== 4'b0001 || {s1, s0} !== 2'b00 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_handover: got gnt=%b sel=%b busy=%b want 0001 00 1", gnt, {s1, s0}, busy);
        end
`endif
    endtask

    // Sole owner 2 drops: idle next edge, select stays 10.
    task automatic test_idle_return();
        do_reset(1);
        req = 4'b0100;
        step();
        step();
        n_checks++;
        if (gnt !== 4'b0100 || {s1, s0} !== 2'b10) begin
            n_errors++; $display("FAIL idle_setup: got gnt=%b sel=%b want 0100 10", gnt, {s1, s0});
        end
        req = 4'b0000;
        step();
        n_checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_return: got gnt=%b busy=%b ov=%b want 0000 0 0", gnt, busy, out_valid);
        end
        n_checks++;
        if ({s1, s0} !== 2'b10 || out !== c) begin
            n_errors++; $display("FAIL idle_sel_keep: got sel=%b out=%h want 10 %h", {s1, s0}, out, c);
        end
    endtask

    // Reset while 3 owns with req=1001: cleared at the reset edge, then 0 wins.
    task automatic test_reset_mid_grant();
        do_reset(1);
        req = 4'b1000;
        step();
        n_checks++;
        if (gnt !== 4'b1000 || out !== d) begin
            n_errors++; $display("FAIL rmg_setup: got gnt=%b out=%h want 1000 %h", gnt, out, d);
        end
        req = 4'b1001;
        step();
        rst = 1'b1;
        step();
        n_checks++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || {s1, s0} !== 2'b00) begin
            n_errors++;
            $display("FAIL rmg_reset_edge: got gnt=%b busy=%b sel=%b want 0000 0 00", gnt, busy, {s1, s0});
        end
        rst = 1'b0;
        step();
        n_checks++;
        if (gnt !== 4'b0001 || {s1, s0} !== 2'b00 || out !== a || out_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL rmg_rearb: got gnt=%b sel=%b out=%h ov=%b want 0001 00 %h 1",
                     gnt, {s1, s0}, out, out_valid, a);
        end
        req = 4'b0000;
        step();
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        a   = 8'hA1;
        b   = 8'hB2;
        c   = 8'hC3;
        d   = 8'hD4;
        test_reset();
        test_single();
`ifndef MUX_ARB_FIXED_PRIO_EN
        test_all_rr();
`else
        test_fixed_prio();
`endif
        test_back_to_back();
        test_idle_return();
        test_reset_mid_grant();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_mux_4x1_rr_arbiter
`default_nettype wire
